hp_bar_ctrl: RTL and testbench

- Battle-screen HP bar controller. Holds target and displayed HP for the CPU and user Pokémon.
- Animates the displayed value toward the target at a fixed frame rate.
- Renders both HP bars as an overlay inside the CPU and user status boxes.
- Sits on the MMIO bus as a slave. Its pixel output is delayed 2 stages to align with the frame/box source output; the video mux selects hp_rgb when hp_en=1.

---
 rtl/hp_bar_ctrl.sv | 148 ++++++++++++++
 tb/tb_hp_bar_ctrl.sv | 184 ++++++++++++++++++
 2 files changed

// File: rtl/hp_bar_ctrl.sv
// Battle-screen HP bar controller: MMIO target/display registers, per-bar
// frame-paced animation FSMs, and a 2-stage pipelined pixel overlay.
module hp_bar_ctrl #(
   parameter int unsigned MAX_HP      = 200,
   parameter int unsigned STEP_FRAMES = 2,
   parameter int unsigned CPU_X0      = 20,
   parameter int unsigned CPU_Y0      = 90,
   parameter int unsigned USR_X0      = 420,
   parameter int unsigned USR_Y0      = 300,
   parameter int unsigned BAR_H       = 8
) (
   input  logic        clk,
   input  logic        reset,
   input  logic        cs,
   input  logic        write,
   input  logic [4:0]  addr,
   input  logic [31:0] wr_data,
   output logic [31:0] rd_data,
   input  logic        frame_tick,
   input  logic [10:0] x,
   input  logic [10:0] y,
   output logic [11:0] hp_rgb,
   output logic        hp_en
);

   localparam int unsigned CW = (STEP_FRAMES > 1) ? $clog2(STEP_FRAMES) : 1;
   localparam logic [CW-1:0] CNT_LAST = CW'(STEP_FRAMES - 1);
   localparam logic [7:0]  MAX8  = 8'(MAX_HP);
   localparam logic [10:0] MAX11 = 11'(MAX_HP);

   typedef enum logic {IDLE, ANIM} bar_state_t;

   bar_state_t    state [2];
   logic [7:0]    disp  [2];
   logic [7:0]    tgt   [2];
   logic [CW-1:0] cnt   [2];
   logic [1:0]    done;

   logic          unused_wr_hi;
   assign unused_wr_hi = ^wr_data[31:8];

   function automatic logic [7:0] clamp_hp(input logic [7:0] d);
      return (d > MAX8) ? MAX8 : d;
   endfunction

   function automatic logic [11:0] bar_colour(input logic [7:0] d);
      logic [10:0] d11;
      d11 = {3'b000, d};
      if ((d11 << 1) > MAX11)
         return 12'h0F0;
      else if (((d11 << 2) + d11) > MAX11)
         return 12'hFF0;
      else
         return 12'hF00;
   endfunction

   // A done set in the same cycle as a done-clear write wins, so no completion is lost.
   always_ff @(posedge clk) begin
      if (reset) begin
         for (int unsigned i = 0; i < 2; i++) begin
            state[i] <= IDLE;
            disp[i]  <= MAX8;
            tgt[i]   <= MAX8;
            cnt[i]   <= '0;
         end
         done <= '0;
      end else begin
         if (cs && write && addr == 5'd3)
            done <= '0;
         for (int unsigned i = 0; i < 2; i++) begin
            if (cs && write && addr == 5'(i))
               tgt[i] <= clamp_hp(wr_data[7:0]);
            if (cs && write && addr == 5'd2 && wr_data[i]) begin
               disp[i]  <= tgt[i];
               state[i] <= IDLE;
               cnt[i]   <= '0;
            end else begin
               case (state[i])
                  IDLE: if (disp[i] != tgt[i]) state[i] <= ANIM;
                  ANIM: begin
                     if (disp[i] == tgt[i]) begin
                        done[i]  <= 1'b1;
                        state[i] <= IDLE;
                        cnt[i]   <= '0;
                     end else if (frame_tick) begin
                        if (cnt[i] == CNT_LAST) begin
                           cnt[i]  <= '0;
                           disp[i] <= (disp[i] < tgt[i]) ? disp[i] + 8'd1 : disp[i] - 8'd1;
                        end else begin
                           cnt[i] <= cnt[i] + CW'(1);
                        end
                     end
                  end
                  default: state[i] <= IDLE;
               endcase
            end
         end
      end
   end

   always_comb begin
      rd_data = '0;
      case (addr)
         5'd0:    rd_data = {15'b0, state[0] == ANIM, disp[0], tgt[0]};
         5'd1:    rd_data = {15'b0, state[1] == ANIM, disp[1], tgt[1]};
         5'd3:    rd_data = {30'b0, done[1], done[0]};
         default: rd_data = '0;
      endcase
   end

   logic        in_cpu, in_usr;
   logic [11:0] pix_rgb;
   logic        pix_en;
   logic [11:0] rgb_s1;
   logic        en_s1;

   assign in_cpu = (x >= 11'(CPU_X0)) && (x < 11'(CPU_X0 + MAX_HP)) &&
                   (y >= 11'(CPU_Y0)) && (y < 11'(CPU_Y0 + BAR_H));
   assign in_usr = (x >= 11'(USR_X0)) && (x < 11'(USR_X0 + MAX_HP)) &&
                   (y >= 11'(USR_Y0)) && (y < 11'(USR_Y0 + BAR_H));

   always_comb begin
      pix_en  = 1'b0;
      pix_rgb = '0;
      if (in_cpu) begin
         pix_en  = 1'b1;
         pix_rgb = (x < 11'(CPU_X0) + {3'b000, disp[0]}) ? bar_colour(disp[0]) : 12'h888;
      end else if (in_usr) begin
         pix_en  = 1'b1;
         pix_rgb = (x < 11'(USR_X0) + {3'b000, disp[1]}) ? bar_colour(disp[1]) : 12'h888;
      end
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         rgb_s1 <= '0;
         en_s1  <= 1'b0;
         hp_rgb <= '0;
         hp_en  <= 1'b0;
      end else begin
         rgb_s1 <= pix_rgb;
         en_s1  <= pix_en;
         hp_rgb <= rgb_s1;
         hp_en  <= en_s1;
      end
   end

endmodule

// File: tb/tb_hp_bar_ctrl.sv
// Directed bench for hp_bar_ctrl: register access, animation pacing,
// retarget/instant/reset behaviour and pipelined pixel colours.
module tb_hp_bar_ctrl;

   localparam int CX = 20, CY = 90, UX = 420, UY = 300;

   logic        clk = 1'b0;
   logic        reset, cs, write, frame_tick;
   logic [4:0]  addr;
   logic [31:0] wr_data, rd_data;
   logic [10:0] x, y;
   logic [11:0] hp_rgb;
   logic        hp_en;

   int total = 0;
   int bad   = 0;

   always #5 clk = ~clk;

   hp_bar_ctrl #(
      .MAX_HP(200), .STEP_FRAMES(2), .CPU_X0(20), .CPU_Y0(90),
      .USR_X0(420), .USR_Y0(300), .BAR_H(8)
   ) dut (
      .clk(clk), .reset(reset), .cs(cs), .write(write), .addr(addr),
      .wr_data(wr_data), .rd_data(rd_data), .frame_tick(frame_tick),
      .x(x), .y(y), .hp_rgb(hp_rgb), .hp_en(hp_en)
   );

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      total++;
      assert (obs === exp) else begin
         bad++;
         $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
      end
   endtask

   task automatic wr(input logic [4:0] a, input logic [31:0] d);
      cs = 1'b1; write = 1'b1; addr = a; wr_data = d;
      @(negedge clk);
      cs = 1'b0; write = 1'b0;
   endtask

   task automatic rd_chk(input string tag, input logic [4:0] a, input logic [31:0] exp);
      addr = a;
      #1;
      check(tag, rd_data, exp);
   endtask

   task automatic ticks(input int n);
      repeat (n) begin
         frame_tick = 1'b1;
         @(negedge clk);
         frame_tick = 1'b0;
         @(negedge clk);
      end
   endtask

   task automatic pix(input string tag, input int px, input int py,
                      input logic en, input logic [11:0] rgb);
      x = 11'(px); y = 11'(py);
      @(negedge clk);
      @(negedge clk);
      check({tag, "_en"}, 32'(hp_en), 32'(en));
      check({tag, "_rgb"}, 32'(hp_rgb), 32'(rgb));
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog expired total=%0d bad=%0d", total, bad);
      $fatal(1, "watchdog");
   end

   initial begin
      reset = 1'b1; cs = 1'b0; write = 1'b0; addr = '0; wr_data = '0;
      frame_tick = 1'b0; x = '0; y = '0;
      repeat (2) @(negedge clk);
      reset = 1'b0;

      rd_chk("rst_cpu", 5'd0, 32'h0000C8C8);
      rd_chk("rst_usr", 5'd1, 32'h0000C8C8);
      rd_chk("rst_done", 5'd3, 32'h0);
      rd_chk("rd_unused", 5'd7, 32'h0);

      x = 11'(CX + 5); y = 11'(CY);
      @(negedge clk);
      check("lat1_en", 32'(hp_en), 32'h0);
      @(negedge clk);
      check("lat2_en", 32'(hp_en), 32'h1);
      check("lat2_rgb", 32'(hp_rgb), 32'h0F0);
      pix("origin", 0, 0, 1'b0, 12'h000);
      pix("usr_last_col", UX + 199, UY + 7, 1'b1, 12'h0F0);
      pix("usr_past_col", UX + 200, UY, 1'b0, 12'h000);

      // CPU drain 200 -> 190
      wr(5'd0, 32'd190);
      @(negedge clk);
      rd_chk("drain_busy", 5'd0, 32'h0001C8BE);
      ticks(2);
      rd_chk("drain_199", 5'd0, 32'h0001C7BE);
      ticks(18);
      rd_chk("drain_190", 5'd0, 32'h0000BEBE);
      rd_chk("drain_done", 5'd3, 32'h1);
      wr(5'd3, 32'h0);
      rd_chk("done_clr", 5'd3, 32'h0);

      // user: instant to 50, then clamped rise toward 200
      wr(5'd1, 32'd50);
      wr(5'd2, 32'h2);
      rd_chk("usr_inst50", 5'd1, 32'h00003232);
      rd_chk("usr_inst_nodone", 5'd3, 32'h0);
      wr(5'd1, 32'd250);
      @(negedge clk);
      rd_chk("usr_clamp", 5'd1, 32'h000132C8);
      ticks(100);
      rd_chk("usr_100", 5'd1, 32'h000164C8);
      pix("usr_yel100", UX, UY, 1'b1, 12'hFF0);
      ticks(2);
      pix("usr_grn101", UX, UY, 1'b1, 12'h0F0);
      pix("usr_edge_in", UX + 100, UY, 1'b1, 12'h0F0);
      pix("usr_edge_gray", UX + 101, UY, 1'b1, 12'h888);
      wr(5'd1, 32'd40);
      wr(5'd2, 32'h2);
      rd_chk("usr_abort_nodone", 5'd3, 32'h0);
      pix("usr_red40", UX, UY, 1'b1, 12'hF00);
      wr(5'd1, 32'd41);
      wr(5'd2, 32'h2);
      pix("usr_yel41", UX, UY, 1'b1, 12'hFF0);
      wr(5'd1, 32'd200);
      wr(5'd2, 32'h2);

      // CPU drain 200 -> 100, reversed to 160 at disp 150
      wr(5'd0, 32'd200);
      wr(5'd2, 32'h1);
      wr(5'd0, 32'd100);
      @(negedge clk);
      ticks(100);
      rd_chk("rev_150", 5'd0, 32'h00019664);
      wr(5'd0, 32'd160);
      ticks(18);
      rd_chk("rev_159", 5'd0, 32'h00019FA0);
      rd_chk("rev_not_done", 5'd3, 32'h0);
      ticks(2);
      rd_chk("rev_160", 5'd0, 32'h0000A0A0);
      rd_chk("rev_done", 5'd3, 32'h1);

      // instant abort at disp 180 toward 30
      wr(5'd3, 32'h0);
      wr(5'd0, 32'd200);
      wr(5'd2, 32'h1);
      wr(5'd0, 32'd30);
      @(negedge clk);
      ticks(40);
      rd_chk("inst_180", 5'd0, 32'h0001B41E);
      wr(5'd2, 32'h1);
      rd_chk("inst_30", 5'd0, 32'h00001E1E);
      rd_chk("inst_nodone", 5'd3, 32'h0);
      pix("cpu_gray30", CX + 30, CY, 1'b1, 12'h888);
      pix("cpu_y_edge", CX + 29, CY + 8, 1'b0, 12'h000);
      pix("cpu_red29", CX + 29, CY, 1'b1, 12'hF00);

      // reset mid-animation at disp 120
      wr(5'd0, 32'd200);
      @(negedge clk);
      ticks(180);
      rd_chk("pre_rst_120", 5'd0, 32'h000178C8);
      x = 11'(CX + 5); y = 11'(CY);
      reset = 1'b1;
      @(negedge clk);
      reset = 1'b0;
      rd_chk("mid_rst_cpu", 5'd0, 32'h0000C8C8);
      rd_chk("mid_rst_done", 5'd3, 32'h0);
      check("mid_rst_en0", 32'(hp_en), 32'h0);
      check("mid_rst_rgb0", 32'(hp_rgb), 32'h0);
      @(negedge clk);
      check("mid_rst_en1", 32'(hp_en), 32'h0);
      @(negedge clk);
      check("mid_rst_en2", 32'(hp_en), 32'h1);
      check("mid_rst_rgb2", 32'(hp_rgb), 32'h0F0);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
